// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB against a variable-latency memory.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap to HALT instead of retiring as NOPs.
module mc_ctrl #(
  parameter int OPCODE_W    = 6,
  parameter int FUNCT_W     = 6,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                write,
  output logic                rd_mux_s,
  output logic                op2_mux_s,
  output logic [FUNCT_W-1:0]  alu_funct,
  output logic                branch_mux_s,
  output logic                j_mux_s,
  output logic [CNT_W-1:0]    instr_count,
  output logic                err,
  output logic [2:0]          dbg_state
);

  // Memory handshake: mem_req stays high until the cycle mem_ready is seen with it;
  // that cycle completes the transfer, and mem_we qualifies it as a store.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [FUNCT_W-1:0]  FN_ADD   = FUNCT_W'(6'h20);
  localparam logic [FUNCT_W-1:0]  FN_SUB   = FUNCT_W'(6'h22);
  localparam logic [OPCODE_W-1:0] OP_R     = '0;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
  localparam logic [31:0]         TO_LIMIT = MEM_TIMEOUT;

  state_t               state, next_state;
  logic [OPCODE_W-1:0]  op_q;
  logic [FUNCT_W-1:0]   fn_q;
  logic [15:0]          wait_cnt;
  logic                 retire, timeout_hit;
  logic                 is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_known;
  logic [FUNCT_W-1:0]   ex_alu;
  logic                 ex_op2;

  assign dbg_state = state;

  assign is_r     = (op_q == OP_R);
  assign is_addi  = (op_q == OP_ADDI);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_beq   = (op_q == OP_BEQ);
  assign is_j     = (op_q == OP_J);
  assign is_known = is_r | is_addi | is_lw | is_sw | is_beq | is_j;

  // ALU controls chosen in EXEC and held unchanged through WB.
  assign ex_alu = is_r ? fn_q : (is_beq ? FN_SUB : FN_ADD);
  assign ex_op2 = is_addi | is_lw | is_sw;

  // The cycle that would make the count of not-ready cycles reach the limit; a ready
  // in that same cycle still completes the transfer.
  assign timeout_hit = (TO_LIMIT != 32'd0) && !mem_ready &&
                       (({16'd0, wait_cnt} + 32'd1) == TO_LIMIT);

  always_comb begin
    next_state   = state;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_write     = 1'b0;
    write        = 1'b0;
    rd_mux_s     = 1'b0;
    op2_mux_s    = 1'b0;
    alu_funct    = FN_ADD;
    branch_mux_s = 1'b0;
    j_mux_s      = 1'b0;
    case (state)
      S_IDLE: if (!load) next_state = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          next_state = S_DECODE;
        end else if (timeout_hit) begin
          next_state = S_HALT;
        end
      end
      S_DECODE: begin
        if (is_known) begin
          next_state = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          next_state = S_HALT;
`else
          next_state = S_FETCH;
          retire     = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        alu_funct = ex_alu;
        op2_mux_s = ex_op2;
        if (is_beq) begin
          branch_mux_s = zero;
          retire       = 1'b1;
          next_state   = S_FETCH;
        end else if (is_j) begin
          j_mux_s    = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (is_lw || is_sw) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        alu_funct = FN_ADD;
        op2_mux_s = 1'b1;
        if (mem_ready) begin
          retire     = is_sw;
          next_state = is_sw ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          next_state = S_HALT;
        end
      end
      S_WB: begin
        write      = 1'b1;
        rd_mux_s   = is_r;
        alu_funct  = ex_alu;
        op2_mux_s  = ex_op2;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
    // A program load abandons whatever is in flight; only HALT ignores it.
    if (load && state != S_HALT) begin
      next_state   = S_IDLE;
      retire       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      ir_write     = 1'b0;
      write        = 1'b0;
      rd_mux_s     = 1'b0;
      op2_mux_s    = 1'b0;
      alu_funct    = FN_ADD;
      branch_mux_s = 1'b0;
      j_mux_s      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      fn_q        <= '0;
      instr_count <= '0;
      err         <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= next_state;
      if (ir_write) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (retire) instr_count <= instr_count + 1'b1;
      if (next_state == S_HALT && state != S_HALT) err <= 1'b1;
      if (next_state != state) wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !mem_ready) wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed instruction stream, event scoreboard with cycle stamps.
module tb_mc_ctrl;
  localparam int CW = 4;
  localparam int RW = 16 + CW + 8 + 6;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd6;

  logic          clock, reset, load, zero, mem_ready;
  logic [5:0]    opcode, funct;
  logic          mem_req, mem_we, ir_write, write, rd_mux_s, op2_mux_s;
  logic [5:0]    alu_funct;
  logic          branch_mux_s, j_mux_s, err;
  logic [CW-1:0] instr_count;
  logic [2:0]    dbg_state;

  logic [RW-1:0] exp_q[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] m_cnt;

  mc_ctrl #(.OPCODE_W(6), .FUNCT_W(6), .CNT_W(CW), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .load(load), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .write(write), .rd_mux_s(rd_mux_s), .op2_mux_s(op2_mux_s),
    .alu_funct(alu_funct), .branch_mux_s(branch_mux_s), .j_mux_s(j_mux_s),
    .instr_count(instr_count), .err(err), .dbg_state(dbg_state)
  );

  // Clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [RW-1:0] mk(input int t, input logic [CW-1:0] cnt,
      input logic irw, input logic wr, input logic rd, input logic op2,
      input logic br, input logic jm, input logic mreq, input logic mwe, input logic [5:0] alu);
    logic [15:0] ts;
    ts = t[15:0];
    return {ts, cnt, irw, wr, rd, op2, br, jm, mreq, mwe, alu};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: handshake completions, EXEC cycles and register writes are the observable events.
  always @(negedge clock) begin
    if (!reset && ((mem_req && mem_ready) || write || dbg_state == ST_EXEC)) begin
      logic [RW-1:0] act, e;
      act = mk(cyc, instr_count, ir_write, write, rd_mux_s, op2_mux_s,
               branch_mux_s, j_mux_s, mem_req, mem_we, alu_funct);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event act=%h exp=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL event act=%h exp=%h", act, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called at the first FETCH cycle; returns at the first FETCH cycle of the next instruction.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw);
    int tf;
    logic [5:0] alu;
    logic op2;
    opcode = op; funct = fn; zero = z;
    if (fw > 0) begin
      mem_ready = 1'b0;
      step(fw);
    end
    mem_ready = 1'b1;
    tf = cyc;
    exp_q.push_back(mk(tf, m_cnt, 1, 0, 0, 0, 0, 0, 1, 0, 6'h20));
    alu = (op == 6'h00) ? fn : (op == 6'h04) ? 6'h22 : 6'h20;
    op2 = (op == 6'h08) || (op == 6'h23) || (op == 6'h2B);
    if (!(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02})) begin
      step(2);
    end else begin
      exp_q.push_back(mk(tf + 2, m_cnt, 0, 0, 0, op2, (op == 6'h04) && z, op == 6'h02, 0, 0, alu));
      if (op == 6'h04 || op == 6'h02) begin
        step(3);
      end else if (op == 6'h23 || op == 6'h2B) begin
        step(3);
        if (mw > 0) begin
          mem_ready = 1'b0;
          step(mw);
          mem_ready = 1'b1;
        end
        exp_q.push_back(mk(tf + 3 + mw, m_cnt, 0, 0, 0, 1, 0, 0, 1, op == 6'h2B, 6'h20));
        if (op == 6'h2B) begin
          step(1);
        end else begin
          exp_q.push_back(mk(tf + 4 + mw, m_cnt, 0, 1, 0, 1, 0, 0, 0, 0, 6'h20));
          step(2);
        end
      end else begin
        exp_q.push_back(mk(tf + 3, m_cnt, 0, 1, op == 6'h00, op2, 0, 0, 0, 0, alu));
        step(4);
      end
    end
    m_cnt = m_cnt + 1'b1;
  endtask

  logic [5:0] fn_tab [7] = '{6'h25, 6'h2A, 6'h26, 6'h27, 6'h20, 6'h22, 6'h24};

  initial begin
    int tf;
    reset = 1; load = 1; mem_ready = 0; opcode = 0; funct = 0; zero = 0;
    m_cnt = '0;
    step(2);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("idle_hold", {dbg_state, mem_req, alu_funct, instr_count, err},
            {ST_IDLE, 1'b0, 6'h20, {CW{1'b0}}, 1'b0});
    end

    load = 0; mem_ready = 1;
    step(1);
    do_instr(6'h00, 6'h20, 0, 0, 0);  // add
    check("count_after_add", instr_count, 1);
    do_instr(6'h00, 6'h22, 0, 0, 0);  // sub
    do_instr(6'h08, 6'h3F, 0, 0, 0);  // addi, funct field ignored
    do_instr(6'h23, 6'h00, 0, 0, 3);  // lw, 3 wait cycles in MEM
    do_instr(6'h2B, 6'h00, 0, 0, 1);  // sw
    do_instr(6'h04, 6'h00, 1, 0, 0);  // beq taken
    do_instr(6'h04, 6'h00, 0, 0, 0);  // beq not taken
    do_instr(6'h02, 6'h00, 0, 2, 0);  // j after 2 fetch waits
    do_instr(6'h00, 6'h24, 0, 3, 0);  // ready on the limit cycle still succeeds
    check("count_mid", instr_count, m_cnt);
`ifdef ILLEGAL_TRAP_EN
    opcode = 6'h3F; mem_ready = 1; tf = cyc;
    exp_q.push_back(mk(tf, m_cnt, 1, 0, 0, 0, 0, 0, 1, 0, 6'h20));
    step(2);
    check("trap_halt", {dbg_state, err, instr_count}, {ST_HALT, 1'b1, m_cnt});
    reset = 1; step(1); reset = 0; m_cnt = '0; step(1);
`else
    do_instr(6'h3F, 6'h00, 0, 0, 0);  // unknown opcode retires as NOP
    check("nop_retired", {dbg_state, err, instr_count}, {ST_FETCH, 1'b0, m_cnt});
`endif
    for (int i = 0; i < 7; i++) do_instr(6'h00, fn_tab[i], 0, 0, 0);
    check("count_wrap", instr_count, m_cnt);

    // Load raised during a lw memory wait; then load and ready together.
    opcode = 6'h23; mem_ready = 1; tf = cyc;
    exp_q.push_back(mk(tf, m_cnt, 1, 0, 0, 0, 0, 0, 1, 0, 6'h20));
    exp_q.push_back(mk(tf + 2, m_cnt, 0, 0, 0, 1, 0, 0, 0, 0, 6'h20));
    step(3);
    mem_ready = 0; step(1);
    load = 1; mem_ready = 1; step(1);
    check("load_abandon", {dbg_state, instr_count}, {ST_IDLE, m_cnt});
    load = 0; step(1);

    // Timeout in FETCH
    opcode = 6'h00; mem_ready = 0;
    step(3);
    check("before_timeout", {dbg_state, err}, {ST_FETCH, 1'b0});
    step(1);
    check("timeout_halt", {dbg_state, err}, {ST_HALT, 1'b1});
    load = 1; mem_ready = 1; step(2);
    load = 0; step(2);
    check("halt_sticky", {dbg_state, err, instr_count, mem_req}, {ST_HALT, 1'b1, m_cnt, 1'b0});
    reset = 1; step(1); reset = 0;
    m_cnt = '0;
    check("reset_clears", {dbg_state, err, instr_count, alu_funct}, {ST_IDLE, 1'b0, m_cnt, 6'h20});

    // Reset during a memory wait
    mem_ready = 0; step(3);
    reset = 1; step(1);
    check("reset_mid_wait", {dbg_state, err, instr_count, mem_req}, {ST_IDLE, 1'b0, m_cnt, 1'b0});
    reset = 0; load = 1; step(2);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
